// File: rtl/pri_grant_sched_if.sv
// rtl/pri_grant_sched_if.sv - request/grant bundle for pri_grant_sched
//
// Groups the batch request side, the grant stream and the status outputs.
//   master : batch producer / grant consumer (drives req_valid, req_vec, flush, gnt_ready)
//   slave  : the scheduler (drives req_ready, gnt_valid, gnt_idx, gnt_last, pending, busy)
interface pri_grant_sched_if #(
    parameter int WIDTH     = 55,
    parameter int WIDTH_LOG = 6
);
    logic                 req_valid;
    logic [WIDTH-1:0]     req_vec;
    logic                 req_ready;
    logic                 flush;
    logic                 gnt_valid;
    logic [WIDTH_LOG-1:0] gnt_idx;
    logic                 gnt_last;
    logic                 gnt_ready;
    logic [WIDTH-1:0]     pending;
    logic                 busy;

    modport master (
        output req_valid, req_vec, flush, gnt_ready,
        input  req_ready, gnt_valid, gnt_idx, gnt_last, pending, busy
    );

    modport slave (
        input  req_valid, req_vec, flush, gnt_ready,
        output req_ready, gnt_valid, gnt_idx, gnt_last, pending, busy
    );
endinterface

// File: rtl/pri_grant_sched.sv
// rtl/pri_grant_sched.sv - iterative highest-index-first grant sequencer
//
// Accepts a request bitmap in IDLE and emits one grant per set bit, highest
// index first. The leading-one search is a binary search evaluated one level
// per clock, so each grant costs WIDTH_LOG search cycles plus one handshake.
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : pri_grant_sched_if.slave (request, grant, flush and status signals)
module pri_grant_sched #(
    parameter int WIDTH     = 55,
    parameter int WIDTH_LOG = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    pri_grant_sched_if.slave   bus
);
    localparam int EXT = 1 << WIDTH_LOG;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ENCODE = 2'd1;
    localparam logic [1:0] ST_GRANT  = 2'd2;

    localparam logic [WIDTH_LOG-1:0] LAST_STEP = WIDTH_LOG'(WIDTH_LOG - 1);

    logic [1:0]           state;
    logic [WIDTH-1:0]     pending;
    logic [EXT-1:0]       win;
    logic [WIDTH_LOG-1:0] step;
    logic [WIDTH_LOG-1:0] idx_acc;
    logic [WIDTH_LOG-1:0] gnt_idx;
    logic                 gnt_last;

    // Search datapath. The live window always sits in the low bits of win;
    // at step k it is 2h bits wide with h = 2^(WIDTH_LOG-1-k). sel is both h
    // and the one-hot index bit decided at this step.
    logic [WIDTH_LOG-1:0] sh;
    logic [WIDTH_LOG-1:0] sel;
    logic [EXT-1:0]       half_mask;
    logic [EXT-1:0]       win_hi;
    logic [EXT-1:0]       win_lo;
    logic                 hit;
    logic [EXT-1:0]       win_next;
    logic [WIDTH_LOG-1:0] idx_next;
    logic [WIDTH-1:0]     pend_after_gnt;
    logic                 last_next;

    always_comb begin
        sh             = LAST_STEP - step;
        sel            = WIDTH_LOG'(1) << sh;
        half_mask      = (EXT'(1) << sel) - EXT'(1);
        win_hi         = (win >> sel) & half_mask;
        win_lo         = win & half_mask;
        hit            = |win_hi;
        win_next       = hit ? win_hi : win_lo;
        idx_next       = hit ? (idx_acc | sel) : idx_acc;
        last_next      = ~|(pending & ~(WIDTH'(1) << idx_next));
        pend_after_gnt = pending & ~(WIDTH'(1) << gnt_idx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pending  <= '0;
            win      <= '0;
            step     <= '0;
            idx_acc  <= '0;
            gnt_idx  <= '0;
            gnt_last <= 1'b0;
        end else if (bus.flush && state != ST_IDLE) begin
            // Abort wins over any handshake at the same edge.
            state   <= ST_IDLE;
            pending <= '0;
            win     <= '0;
            step    <= '0;
            idx_acc <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // An all-zero batch is accepted and dropped.
                    if (bus.req_valid && |bus.req_vec) begin
                        pending <= bus.req_vec;
                        win     <= EXT'(bus.req_vec);
                        step    <= '0;
                        idx_acc <= '0;
                        state   <= ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    win     <= win_next;
                    idx_acc <= idx_next;
                    if (step == LAST_STEP) begin
                        gnt_idx  <= idx_next;
                        gnt_last <= last_next;
                        step     <= '0;
                        state    <= ST_GRANT;
                    end else begin
                        step <= step + WIDTH_LOG'(1);
                    end
                end
                ST_GRANT: begin
                    if (bus.gnt_ready) begin
                        pending <= pend_after_gnt;
                        step    <= '0;
                        idx_acc <= '0;
                        if (|pend_after_gnt) begin
                            win   <= EXT'(pend_after_gnt);
                            state <= ST_ENCODE;
                        end else begin
                            win   <= '0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.gnt_valid = (state == ST_GRANT);
    assign bus.gnt_idx   = gnt_idx;
    assign bus.gnt_last  = gnt_last;
    assign bus.pending   = pending;
endmodule

// File: tb/tb_pri_grant_sched.sv
// tb/tb_pri_grant_sched.sv - directed self-checking bench for pri_grant_sched
module tb_pri_grant_sched;
    localparam int WIDTH     = 55;
    localparam int WIDTH_LOG = 6;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pri_grant_sched_if #(.WIDTH(WIDTH), .WIDTH_LOG(WIDTH_LOG)) bus ();

    pri_grant_sched #(.WIDTH(WIDTH), .WIDTH_LOG(WIDTH_LOG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Offer a batch for one edge, then scribble req_vec to show it is ignored.
    task automatic send(input logic [WIDTH-1:0] vec);
        bus.req_valid = 1'b1;
        bus.req_vec   = vec;
        tick();
        bus.req_valid = 1'b0;
        bus.req_vec   = '1;
    endtask

    task automatic wait_gnt(input string tag, output int cyc);
        cyc = 0;
        while (!bus.gnt_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        if (!bus.gnt_valid) chk({tag, "_timeout"}, 64'(bus.gnt_valid), 64'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pending"},   64'(bus.pending),   64'd0);
        chk({tag, "_gnt_valid"}, 64'(bus.gnt_valid), 64'd0);
        chk({tag, "_gnt_idx"},   64'(bus.gnt_idx),   64'd0);
        chk({tag, "_gnt_last"},  64'(bus.gnt_last),  64'd0);
        chk({tag, "_busy"},      64'(bus.busy),      64'd0);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        int cyc;
        int seen;
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_vec   = '0;
        bus.flush     = 1'b0;
        bus.gnt_ready = 1'b0;
        repeat (3) tick();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();

        // Single bit 37
        bus.gnt_ready = 1'b1;
        send(WIDTH'(1) << 37);
        wait_gnt("b37", cyc);
        chk("b37_lat",  64'(cyc),          64'd6);
        chk("b37_idx",  64'(bus.gnt_idx),  64'd37);
        chk("b37_last", 64'(bus.gnt_last), 64'd1);
        tick();
        chk("b37_busy", 64'(bus.busy),     64'd0);
        chk("b37_pend", 64'(bus.pending),  64'd0);

        // Full batch: 54 down to 0, one grant every 7 cycles
        send('1);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            wait_gnt("full", cyc);
            chk($sformatf("full%0d_lat", i),  64'(cyc),          64'd6);
            chk($sformatf("full%0d_idx", i),  64'(bus.gnt_idx),  64'(i));
            chk($sformatf("full%0d_last", i), 64'(bus.gnt_last), 64'(i == 0));
            chk($sformatf("full%0d_pend", i), 64'(bus.pending),  (64'd1 << (i + 1)) - 64'd1);
            tick();
        end
        chk("full_busy", 64'(bus.busy), 64'd0);

        // Stall with gnt_ready low
        bus.gnt_ready = 1'b0;
        send(WIDTH'(5));
        wait_gnt("stall", cyc);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 64'(bus.gnt_valid), 64'd1);
            chk("stall_idx",   64'(bus.gnt_idx),   64'd2);
            chk("stall_pend",  64'(bus.pending),   64'd5);
            tick();
        end
        bus.gnt_ready = 1'b1;
        tick();
        chk("stall_pend_after", 64'(bus.pending), 64'd1);
        wait_gnt("stall2", cyc);
        chk("stall2_lat",  64'(cyc),          64'd6);
        chk("stall2_idx",  64'(bus.gnt_idx),  64'd0);
        chk("stall2_last", 64'(bus.gnt_last), 64'd1);
        tick();
        chk("stall_busy", 64'(bus.busy), 64'd0);

        // Flush in the third ENCODE cycle
        send(WIDTH'(7));
        tick();
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fl1_busy",  64'(bus.busy),      64'd0);
        chk("fl1_pend",  64'(bus.pending),   64'd0);
        chk("fl1_valid", 64'(bus.gnt_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.gnt_valid) seen++;
            tick();
        end
        chk("fl1_no_gnt", 64'(seen), 64'd0);

        // Flush together with a handshake in GRANT
        send(WIDTH'(7));
        wait_gnt("fl2", cyc);
        chk("fl2_idx", 64'(bus.gnt_idx), 64'd2);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fl2_busy",  64'(bus.busy),      64'd0);
        chk("fl2_pend",  64'(bus.pending),   64'd0);
        chk("fl2_valid", 64'(bus.gnt_valid), 64'd0);

        // Flush in IDLE does not block acceptance
        bus.flush = 1'b1;
        send(WIDTH'(2));
        bus.flush = 1'b0;
        chk("fl3_busy", 64'(bus.busy),    64'd1);
        chk("fl3_pend", 64'(bus.pending), 64'd2);
        wait_gnt("fl3", cyc);
        chk("fl3_idx", 64'(bus.gnt_idx), 64'd1);
        tick();

        // Reset during GRANT
        bus.gnt_ready = 1'b0;
        send(WIDTH'(3));
        wait_gnt("mid", cyc);
        chk("mid_idx", 64'(bus.gnt_idx), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset_vals("midrst");
        bus.gnt_ready = 1'b1;
        send(WIDTH'(16));
        wait_gnt("post", cyc);
        chk("post_lat", 64'(cyc),         64'd6);
        chk("post_idx", 64'(bus.gnt_idx), 64'd4);
        tick();

        // Zero batch, then the two edge indices
        send('0);
        chk("zero_ready", 64'(bus.req_ready), 64'd1);
        chk("zero_busy",  64'(bus.busy),      64'd0);
        send(WIDTH'(1) << 54);
        wait_gnt("top", cyc);
        chk("top_idx",  64'(bus.gnt_idx),  64'd54);
        chk("top_last", 64'(bus.gnt_last), 64'd1);
        tick();
        send(WIDTH'(1));
        wait_gnt("bot", cyc);
        chk("bot_idx",  64'(bus.gnt_idx),  64'd0);
        chk("bot_last", 64'(bus.gnt_last), 64'd1);
        tick();
        chk("bot_busy", 64'(bus.busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
